// File: rtl/bram_row_streamer_if.sv
// AXI-Stream bundle used by bram_row_streamer for its output stream.
//   tdata  : stream word
//   tvalid : word valid
//   tready : consumer ready
//   tlast  : final word of the requested row range
// master drives tdata/tvalid/tlast and samples tready; slave is the mirror image.
interface bram_row_streamer_if #(
   parameter int unsigned WORD_WIDTH = 32
) ();
   logic [WORD_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/bram_row_streamer.sv
// Fetches BRAM rows start_index..bound_index (inclusive, modulo address space) and serializes
// each wide row into WORDS_PER_ROW AXI-Stream words, tlast on the final word of the final row.
// A one-row prefetch buffer hides the BRAM read latency across row boundaries.
// Ports:
//   clk, rstn                : clock, synchronous active-low reset
//   start, start_index,
//   bound_index              : range request, sampled only while busy=0
//   busy, done               : status; done pulses one cycle after the tlast handshake
//   bram_en, bram_addr       : one-cycle read request per row
//   bram_rdata               : row data, valid READ_LATENCY cycles after bram_en
//   m_axis                   : AXI-Stream master (tdata/tvalid/tready/tlast)
module bram_row_streamer #(
   parameter int unsigned BRAM_DEPTH    = 12,
   parameter int unsigned WORD_WIDTH    = 32,
   parameter int unsigned WORDS_PER_ROW = 36,
   parameter int unsigned READ_LATENCY  = 2
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                start,
   input  logic [BRAM_DEPTH-1:0]               start_index,
   input  logic [BRAM_DEPTH-1:0]               bound_index,
   output logic                                busy,
   output logic                                done,
   output logic                                bram_en,
   output logic [BRAM_DEPTH-1:0]               bram_addr,
   input  logic [WORDS_PER_ROW*WORD_WIDTH-1:0] bram_rdata,
   bram_row_streamer_if.master                 m_axis
);
   localparam int unsigned RowWidth  = WORDS_PER_ROW * WORD_WIDTH;
   localparam int unsigned WCntWidth = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam logic [WCntWidth-1:0] LastWord = WCntWidth'(WORDS_PER_ROW - 1);
   localparam logic [BRAM_DEPTH:0]  OneRow   = (BRAM_DEPTH + 1)'(1);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StStream, StDone} state_e;

   state_e                  state_q, state_d;
   logic [BRAM_DEPTH-1:0]   addr_q, addr_d;
   logic [BRAM_DEPTH:0]     issue_left_q, issue_left_d;  // rows not yet requested
   logic [BRAM_DEPTH:0]     rows_left_q, rows_left_d;    // rows not yet fully streamed
   logic [READ_LATENCY-1:0] tag_q, tag_d;                // in-flight read tags
   logic [RowWidth-1:0]     out_buf_q, out_buf_d;
   logic                    out_vld_q, out_vld_d;
   logic [RowWidth-1:0]     pf_buf_q, pf_buf_d;
   logic                    pf_vld_q, pf_vld_d;
   logic [WCntWidth-1:0]    w_q, w_d;

   logic [BRAM_DEPTH:0] n_rows;
   logic                accept;
   logic                in_flight;
   logic                land;
   logic                hs;
   logic                row_end;
   logic                last_row;
   logic                last_hs;
   logic                out_free;

   // Width BRAM_DEPTH+1 so that bound == start-1 yields the full 2^BRAM_DEPTH rows.
   assign n_rows    = {1'b0, bound_index - start_index} + OneRow;
   assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
   assign in_flight = |tag_q;
   assign land      = tag_q[READ_LATENCY-1];
   assign hs        = out_vld_q && m_axis.tready;
   assign row_end   = hs && (w_q == LastWord);
   assign last_row  = (rows_left_q == OneRow);
   assign last_hs   = row_end && last_row;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (accept) state_d = StIssue;
         StIssue:  state_d = StWait;
         StWait:   if (land) state_d = StStream;
         StStream: if (last_hs) state_d = StDone;
         StDone:   state_d = accept ? StIssue : StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      bram_en = 1'b0;
      case (state_q)
         StIssue: begin
            busy    = 1'b1;
            bram_en = 1'b1;
         end
         StWait: busy = 1'b1;
         StStream: begin
            busy    = 1'b1;
            // Prefetch: one read outstanding at most, only into an empty prefetch slot.
            bram_en = (issue_left_q != '0) && !pf_vld_q && !in_flight;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      addr_d       = addr_q;
      issue_left_d = issue_left_q;
      rows_left_d  = rows_left_q;
      out_buf_d    = out_buf_q;
      out_vld_d    = out_vld_q;
      pf_buf_d     = pf_buf_q;
      pf_vld_d     = pf_vld_q;
      w_d          = w_q;
      out_free     = !out_vld_q;
      tag_d        = tag_q << 1;
      tag_d[0]     = bram_en;

      if (hs) begin
         w_d = w_q + WCntWidth'(1);
      end

      if (row_end) begin
         w_d         = '0;
         rows_left_d = rows_left_q - OneRow;
         if (pf_vld_q) begin
            // Seamless row switch: next row is already buffered.
            out_buf_d = pf_buf_q;
            pf_vld_d  = 1'b0;
         end else begin
            out_vld_d = 1'b0;
            out_free  = 1'b1;
         end
      end

      if (land) begin
         if (out_free) begin
            out_buf_d = bram_rdata;
            out_vld_d = 1'b1;
         end else begin
            pf_buf_d = bram_rdata;
            pf_vld_d = 1'b1;
         end
      end

      if (bram_en) begin
         addr_d       = addr_q + BRAM_DEPTH'(1);
         issue_left_d = issue_left_q - OneRow;
      end

      if (accept) begin
         addr_d       = start_index;
         issue_left_d = n_rows;
         rows_left_d  = n_rows;
         w_d          = '0;
         out_vld_d    = 1'b0;
         pf_vld_d     = 1'b0;
      end
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_q       <= '0;
         issue_left_q <= '0;
         rows_left_q  <= '0;
         tag_q        <= '0;
         out_buf_q    <= '0;
         out_vld_q    <= 1'b0;
         pf_buf_q     <= '0;
         pf_vld_q     <= 1'b0;
         w_q          <= '0;
      end else begin
         addr_q       <= addr_d;
         issue_left_q <= issue_left_d;
         rows_left_q  <= rows_left_d;
         tag_q        <= tag_d;
         out_buf_q    <= out_buf_d;
         out_vld_q    <= out_vld_d;
         pf_buf_q     <= pf_buf_d;
         pf_vld_q     <= pf_vld_d;
         w_q          <= w_d;
      end
   end

   assign bram_addr     = addr_q;
   assign m_axis.tvalid = out_vld_q;
   assign m_axis.tlast  = out_vld_q && (w_q == LastWord) && last_row;

   // Word select; held at zero while no word is presented.
   always_comb begin
      m_axis.tdata = '0;
      for (int unsigned k = 0; k < WORDS_PER_ROW; k++) begin
         if (out_vld_q && (w_q == WCntWidth'(k))) begin
            m_axis.tdata = out_buf_q[k*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   end
endmodule

// File: tb/tb_bram_row_streamer.sv
// Self-checking bench for bram_row_streamer: BRAM model with fixed read latency, random
// tready, and a queue-based reference of the expected word stream per requested range.
module tb_bram_row_streamer;
   localparam int unsigned BD   = 12;
   localparam int unsigned WW   = 32;
   localparam int unsigned WPR  = 36;
   localparam int unsigned RL   = 2;
   localparam int          Rows = 1 << BD;

   logic          clk         = 1'b0;
   logic          rstn        = 1'b0;
   logic          start       = 1'b0;
   logic [BD-1:0] start_index = '0;
   logic [BD-1:0] bound_index = '0;
   logic          busy;
   logic          done;
   logic          bram_en;
   logic [BD-1:0] bram_addr;
   logic [WPR*WW-1:0] bram_rdata;

   bram_row_streamer_if #(.WORD_WIDTH(WW)) axis ();

   bram_row_streamer #(
      .BRAM_DEPTH   (BD),
      .WORD_WIDTH   (WW),
      .WORDS_PER_ROW(WPR),
      .READ_LATENCY (RL)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .start_index(start_index),
      .bound_index(bound_index),
      .busy       (busy),
      .done       (done),
      .bram_en    (bram_en),
      .bram_addr  (bram_addr),
      .bram_rdata (bram_rdata),
      .m_axis     (axis)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- tready driver ----------------
   int unsigned ready_pct = 100;
   always @(posedge clk) begin
      #1;
      axis.tready = ($urandom_range(99) < ready_pct);
   end

   // ---------------- BRAM model: row r word k = {r, k} ----------------
   logic [BD-1:0] pipe_addr [RL] = '{default: '0};
   logic          pipe_vld  [RL] = '{default: 1'b0};
   logic [WW-1:0] junk = '0;
   always @(posedge clk) begin
      pipe_vld[0]  <= (bram_en === 1'b1);
      pipe_addr[0] <= bram_addr;
      for (int i = 1; i < RL; i++) begin
         pipe_vld[i]  <= pipe_vld[i-1];
         pipe_addr[i] <= pipe_addr[i-1];
      end
      junk <= $urandom;
   end
   always_comb begin
      for (int k = 0; k < WPR; k++) begin
         bram_rdata[k*WW +: WW] = pipe_vld[RL-1] ? {16'(pipe_addr[RL-1]), 16'(k)}
                                                 : (junk ^ WW'(k));
      end
   end

   // ---------------- Monitor ----------------
   logic [WW-1:0] obs_data [$];
   logic          obs_last [$];
   int            obs_cyc  [$];
   logic [BD-1:0] obs_addr [$];
   int            n_unstable = 0;
   logic          prev_stall = 1'b0;
   logic [WW-1:0] prev_data  = '0;
   logic          prev_last  = 1'b0;

   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (prev_stall && (axis.tvalid !== 1'b1 || axis.tdata !== prev_data ||
                            axis.tlast !== prev_last)) begin
            n_unstable++;
         end
         if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
            obs_data.push_back(axis.tdata);
            obs_last.push_back(axis.tlast);
            obs_cyc.push_back(cyc);
         end
         if (bram_en === 1'b1) obs_addr.push_back(bram_addr);
      end
      prev_stall = (rstn === 1'b1) && (axis.tvalid === 1'b1) && (axis.tready !== 1'b1);
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
   end

   // ---------------- Reference model ----------------
   logic [WW-1:0] exp_data [$];
   int            exp_rows [$];

   task automatic build_exp(input int s, input int b);
      int n;
      n = (((b - s) % Rows) + Rows) % Rows + 1;
      exp_data.delete();
      exp_rows.delete();
      for (int i = 0; i < n; i++) begin
         int r;
         r = (s + i) % Rows;
         exp_rows.push_back(r);
         for (int k = 0; k < WPR; k++) exp_data.push_back({16'(r), 16'(k)});
      end
   endtask

   task automatic do_start(input int s, input int b, output int e);
      start_index = BD'(s);
      bound_index = BD'(b);
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e     = cyc;  // cycle 1 relative to the accepting edge
   endtask

   task automatic wait_done(input int budget, output bit ok, output int dcyc);
      ok   = 1'b0;
      dcyc = -1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok   = 1'b1;
            dcyc = cyc;
         end
      end
   endtask

   // ---------------- Scenarios ----------------
   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
      n_checks++; if (bram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b exp 0", bram_en); end
      n_checks++; if (bram_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", bram_addr); end
      n_checks++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b exp 0", axis.tvalid); end
      n_checks++; if (axis.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b exp 0", axis.tlast); end
      n_checks++; if (axis.tdata !== '0) begin n_fail++; $display("FAIL reset_tdata got %h exp 0", axis.tdata); end
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic test_single_row();
      int e, dc, bd, ba;
      bit ok;
      ready_pct = 100;
      @(posedge clk); #1;
      bd = obs_data.size(); ba = obs_addr.size();
      build_exp(5, 5);
      do_start(5, 5, e);
      wait_done(200, ok, dc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL single_done got none exp pulse"); end
      n_checks++; if (dc - e + 1 != 40) begin n_fail++; $display("FAIL single_done_cyc got %0d exp 40", dc - e + 1); end
      n_checks++; if (obs_data.size() - bd != 36) begin n_fail++; $display("FAIL single_count got %0d exp 36", obs_data.size() - bd); end
      for (int i = 0; i < exp_data.size() && bd + i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_data[bd+i] !== exp_data[i] || obs_last[bd+i] !== (i == exp_data.size() - 1)) begin
            n_fail++;
            $display("FAIL single_word[%0d] got %h/%b exp %h/%b", i, obs_data[bd+i], obs_last[bd+i],
                     exp_data[i], i == exp_data.size() - 1);
         end
      end
      if (obs_data.size() - bd == 36) begin
         n_checks++; if (obs_cyc[bd] - e + 1 != 4) begin n_fail++; $display("FAIL single_first_cyc got %0d exp 4", obs_cyc[bd] - e + 1); end
         n_checks++; if (obs_cyc[bd+35] - e + 1 != 39) begin n_fail++; $display("FAIL single_last_cyc got %0d exp 39", obs_cyc[bd+35] - e + 1); end
      end
      n_checks++;
      if (obs_addr.size() - ba != 1 || obs_addr[ba] !== BD'(5)) begin
         n_fail++; $display("FAIL single_reads got %0d reads exp 1 at 5", obs_addr.size() - ba);
      end
   endtask

   // Shared body for range runs: stream content, read order, completion.
   task automatic test_range(input string tag, input int s, input int b, input int unsigned pct,
                             input bit no_gap);
      int e, dc, bd, ba, bu, gaps;
      bit ok;
      ready_pct = pct;
      @(posedge clk); #1;
      bd = obs_data.size(); ba = obs_addr.size(); bu = n_unstable;
      build_exp(s, b);
      do_start(s, b, e);
      wait_done(40 * exp_data.size() + 100, ok, dc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_done got none exp pulse", tag); end
      n_checks++;
      if (obs_data.size() - bd != exp_data.size()) begin
         n_fail++; $display("FAIL %s_count got %0d exp %0d", tag, obs_data.size() - bd, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && bd + i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_data[bd+i] !== exp_data[i] || obs_last[bd+i] !== (i == exp_data.size() - 1)) begin
            n_fail++;
            $display("FAIL %s_word[%0d] got %h/%b exp %h/%b", tag, i, obs_data[bd+i], obs_last[bd+i],
                     exp_data[i], i == exp_data.size() - 1);
         end
      end
      n_checks++;
      if (obs_addr.size() - ba != exp_rows.size()) begin
         n_fail++; $display("FAIL %s_reads got %0d exp %0d", tag, obs_addr.size() - ba, exp_rows.size());
      end
      for (int i = 0; i < exp_rows.size() && ba + i < obs_addr.size(); i++) begin
         n_checks++;
         if (obs_addr[ba+i] !== BD'(exp_rows[i])) begin
            n_fail++; $display("FAIL %s_addr[%0d] got %0d exp %0d", tag, i, obs_addr[ba+i], exp_rows[i]);
         end
      end
      n_checks++;
      if (n_unstable != bu) begin
         n_fail++; $display("FAIL %s_stall_stable got %0d changes exp 0", tag, n_unstable - bu);
      end
      if (no_gap) begin
         gaps = 0;
         for (int i = bd + 1; i < obs_data.size(); i++) if (obs_cyc[i] != obs_cyc[i-1] + 1) gaps++;
         n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL %s_gaps got %0d exp 0", tag, gaps); end
      end
   endtask

   task automatic test_multi_row();
      test_range("multi", 0, 3, 100, 1'b1);
   endtask

   task automatic test_backpressure();
      test_range("bp", 10, 12, 30, 1'b0);
   endtask

   task automatic test_wrap();
      test_range("wrap", 4094, 1, 70, 1'b0);
   endtask

   task automatic test_random_ranges();
      for (int t = 0; t < 3; t++) begin
         int s, n;
         s = int'($urandom_range(Rows - 1));
         n = int'($urandom_range(3, 1));
         test_range("rand", s, (s + n - 1) % Rows, $urandom_range(100, 40), 1'b0);
      end
   endtask

   task automatic test_start_while_busy();
      int e, dc, bd, ba;
      bit ok;
      ready_pct = 100;
      @(posedge clk); #1;
      bd = obs_data.size(); ba = obs_addr.size();
      build_exp(20, 21);
      do_start(20, 21, e);
      repeat (28) @(posedge clk);
      #1;
      start_index = BD'(100); bound_index = BD'(300); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (38) @(posedge clk);
      #1;
      start_index = BD'(7); bound_index = BD'(9); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_done(200, ok, dc);
      repeat (8) @(negedge clk);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_done got none exp pulse"); end
      n_checks++;
      if (obs_data.size() - bd != exp_data.size()) begin
         n_fail++; $display("FAIL busy_count got %0d exp %0d", obs_data.size() - bd, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && bd + i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_data[bd+i] !== exp_data[i]) begin
            n_fail++; $display("FAIL busy_word[%0d] got %h exp %h", i, obs_data[bd+i], exp_data[i]);
         end
      end
      n_checks++;
      if (obs_addr.size() - ba != 2 || obs_addr[ba] !== BD'(20) || obs_addr[ba+1] !== BD'(21)) begin
         n_fail++; $display("FAIL busy_reads got %0d reads exp 2 at 20,21", obs_addr.size() - ba);
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle got %b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      int e, e2, dc, bd;
      bit ok;
      ready_pct = 100;
      @(posedge clk); #1;
      do_start(40, 40, e);
      wait_done(200, ok, dc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_first_done got none exp pulse"); end
      // Still inside the done cycle: this start must be accepted.
      bd = obs_data.size();
      build_exp(41, 42);
      do_start(41, 42, e2);
      @(negedge clk);
      n_checks++; if (busy !== 1'b1 || bram_en !== 1'b1 || bram_addr !== BD'(41)) begin
         n_fail++; $display("FAIL b2b_issue got busy=%b en=%b addr=%0d exp 1/1/41", busy, bram_en, bram_addr);
      end
      wait_done(300, ok, dc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_done got none exp pulse"); end
      n_checks++;
      if (obs_data.size() - bd != exp_data.size()) begin
         n_fail++; $display("FAIL b2b_count got %0d exp %0d", obs_data.size() - bd, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && bd + i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_data[bd+i] !== exp_data[i]) begin
            n_fail++; $display("FAIL b2b_word[%0d] got %h exp %h", i, obs_data[bd+i], exp_data[i]);
         end
      end
      if (obs_data.size() > bd) begin
         n_checks++; if (obs_cyc[bd] - e2 + 1 != 4) begin
            n_fail++; $display("FAIL b2b_first_cyc got %0d exp 4", obs_cyc[bd] - e2 + 1);
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      int e, dc, bd, ba;
      bit ok, hit;
      ready_pct = 100;
      @(posedge clk); #1;
      bd = obs_data.size();
      do_start(30, 32, e);
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(negedge clk);
         if (obs_data.size() - bd >= 50) hit = 1'b1;
      end
      n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_reach_w50 got %0d words exp 50", obs_data.size() - bd); end
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, bram_en, axis.tvalid, axis.tlast} !== 5'b0 || bram_addr !== '0 || axis.tdata !== '0) begin
         n_fail++;
         $display("FAIL rst_outputs got busy=%b done=%b en=%b addr=%h v=%b l=%b d=%h exp all 0",
                  busy, done, bram_en, bram_addr, axis.tvalid, axis.tlast, axis.tdata);
      end
      bd = obs_data.size(); ba = obs_addr.size();
      repeat (6) @(negedge clk);
      n_checks++; if (obs_data.size() != bd || obs_addr.size() != ba) begin
         n_fail++; $display("FAIL rst_quiet got %0d words %0d reads exp 0/0", obs_data.size() - bd, obs_addr.size() - ba);
      end
      build_exp(7, 7);
      do_start(7, 7, e);
      wait_done(200, ok, dc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_new_done got none exp pulse"); end
      n_checks++;
      if (obs_data.size() - bd != 36) begin
         n_fail++; $display("FAIL rst_new_count got %0d exp 36", obs_data.size() - bd);
      end
      for (int i = 0; i < exp_data.size() && bd + i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_data[bd+i] !== exp_data[i] || obs_last[bd+i] !== (i == 35)) begin
            n_fail++; $display("FAIL rst_new_word[%0d] got %h exp %h", i, obs_data[bd+i], exp_data[i]);
         end
      end
      n_checks++;
      if (obs_addr.size() - ba != 1 || obs_addr[ba] !== BD'(7)) begin
         n_fail++; $display("FAIL rst_new_reads got %0d reads exp 1 at 7", obs_addr.size() - ba);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_row();
      test_multi_row();
      test_backpressure();
      test_wrap();
      test_random_ranges();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
